uart_pixel_packer: RTL and testbench

//  Upstream stage of the frame-buffer RAM controller. Takes the UART receiver's byte

---
 rtl/uart_pixel_packer_pkg.sv | 37 +++
 rtl/uart_pixel_packer_byte_timeout_ctr.sv | 40 ++++
 rtl/uart_pixel_packer.sv | 139 +++++++++++++
 tb/tb_uart_pixel_packer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pixel_packer_pkg.sv
// ---------------------------------------------------------------------------
// uart_pixel_packer_pkg
//   Shared definitions for the UART pixel packer and its neighbours in the
//   frame-buffer RAM controller.
//   - pk_state_e : 2-bit packer FSM encoding (HUNT0, HUNT1, PIX_LO, PIX_HI)
//   - HDR0_DEF / HDR1_DEF : default frame header bytes
//   - PIX_W / IDX_W : pixel and pixel-index widths
//   - TOP_ST_* : top-level controller state codes shared with the RAM
//     controller and the top (the packer is enabled in TOP_ST_RECV)
//   - pack_pixel : assembles {B,G,R} from the lo byte and the hi-byte nibble
// ---------------------------------------------------------------------------
package uart_pixel_packer_pkg;

  typedef enum logic [1:0] {
    HUNT0  = 2'd0,
    HUNT1  = 2'd1,
    PIX_LO = 2'd2,
    PIX_HI = 2'd3
  } pk_state_e;

  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;

  localparam int PIX_W = 12;
  localparam int IDX_W = 15;

  localparam logic [7:0] TOP_ST_IDLE = 8'h01;
  localparam logic [7:0] TOP_ST_RECV = 8'h02;
  localparam logic [7:0] TOP_ST_SEND = 8'h03;

  // lo byte carries {G,R}; only the low nibble of the hi byte (B) is used.
  function automatic logic [PIX_W-1:0] pack_pixel(input logic [7:0] lo,
                                                   input logic [3:0] b_nib);
    return {b_nib, lo};
  endfunction

endpackage

// File: rtl/uart_pixel_packer_byte_timeout_ctr.sv
// ---------------------------------------------------------------------------
// uart_pixel_packer_byte_timeout_ctr
//   Inter-byte timeout counter for the pixel packer.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clear      : zero the counter (a byte arrived, or the packer is disabled)
//     run        : count this cycle (packer is inside a frame)
//     expire     : high while the counter sits at TIMEOUT_CYC-1 with run set
//                  and no clear; the packer aborts on it
//   The counter saturates at TIMEOUT_CYC-1 instead of wrapping, so a stalled
//   stream can never look like a fresh one.
// ---------------------------------------------------------------------------
module uart_pixel_packer_byte_timeout_ctr #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [23:0] LIMIT = TIMEOUT_CYC - 24'd1;

  logic [23:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != LIMIT)) begin
      cnt <= cnt + 24'd1;
    end
  end

  // A byte on the expiring cycle wins: clear masks the expire pulse.
  assign expire = run && !clear && (cnt == LIMIT);

endmodule

// File: rtl/uart_pixel_packer.sv
// ---------------------------------------------------------------------------
// uart_pixel_packer
//   Receive-side stage of the frame-buffer RAM controller. Hunts for the
//   two-byte frame header in the UART byte stream, then packs byte pairs
//   into 12-bit pixels {B[3:0],G[3:0],R[3:0]} for the RAM writer.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     en            : 1 = accept bytes (top state TOP_ST_RECV); 0 = forced idle
//     byte_valid    : 1-cycle strobe from the UART receiver
//     byte_data     : received byte, valid with byte_valid
//     rx_valid      : 1-cycle pixel strobe, one clk after the hi byte
//     rx_data       : pixel, held until the next strobe
//     pix_index     : index of the pixel being assembled, 0..W*H-1
//     frame_active  : header accepted and frame not yet finished/aborted
//     frame_done    : pulses together with the last pixel's rx_valid
//     err_timeout   : sticky inter-byte timeout flag, cleared by en=0
//     dbg_state     : current packer FSM state
//
//   Strobe protocol: there is no backpressure. byte_valid and rx_valid are
//   single-cycle qualifiers; data is consumed on the posedge where the
//   strobe is high. Since each pixel needs two bytes, rx_valid is never
//   high on two consecutive cycles, which the negedge-sampling RAM writer
//   relies on.
//
//   pix_index is 15 bits wide, so W*H must not exceed 32768.
// ---------------------------------------------------------------------------
module uart_pixel_packer
  import uart_pixel_packer_pkg::*;
#(
  parameter int          W           = 50,
  parameter int          H           = 40,
  parameter logic [7:0]  HDR0        = HDR0_DEF,
  parameter logic [7:0]  HDR1        = HDR1_DEF,
  parameter logic [23:0] TIMEOUT_CYC = 24'd500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             rx_valid,
  output logic [PIX_W-1:0] rx_data,
  output logic [IDX_W-1:0] pix_index,
  output logic             frame_active,
  output logic             frame_done,
  output logic             err_timeout,
  output pk_state_e        dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = 15'(W * H - 1);

  pk_state_e  state_q;
  logic [7:0] lo_byte;
  logic       tmo_clear;
  logic       tmo_run;
  logic       tmo_expire;

  // Counter restarts on every byte and whenever the packer is disabled;
  // it only advances while a frame is being received.
  assign tmo_clear = !en || byte_valid;
  assign tmo_run   = en && ((state_q == PIX_LO) || (state_q == PIX_HI));

  uart_pixel_packer_byte_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .run    (tmo_run),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT0;
      lo_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      pix_index    <= '0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
      if (!en) begin
        // Forced idle; rx_data keeps the last pixel for the RAM writer.
        state_q      <= HUNT0;
        pix_index    <= '0;
        frame_active <= 1'b0;
        err_timeout  <= 1'b0;
      end else if (byte_valid) begin
        case (state_q)
          HUNT0: begin
            if (byte_data == HDR0) state_q <= HUNT1;
          end
          HUNT1: begin
            if (byte_data == HDR1) begin
              state_q      <= PIX_LO;
              frame_active <= 1'b1;
              pix_index    <= '0;
            end else if (byte_data != HDR0) begin
              // A repeated HDR0 may still be the start of a header.
              state_q <= HUNT0;
            end
          end
          PIX_LO: begin
            // Header values are ordinary pixel data here; no resync.
            lo_byte <= byte_data;
            state_q <= PIX_HI;
          end
          PIX_HI: begin
            rx_data  <= pack_pixel(lo_byte, byte_data[3:0]);
            rx_valid <= 1'b1;
            if (pix_index == LAST_IDX) begin
              frame_done   <= 1'b1;
              frame_active <= 1'b0;
              pix_index    <= '0;
              state_q      <= HUNT0;
            end else begin
              pix_index <= pix_index + 15'd1;
              state_q   <= PIX_LO;
            end
          end
          default: state_q <= HUNT0;
        endcase
      end else if (tmo_expire) begin
        // Abort: partial pixel is dropped, no rx_valid.
        state_q      <= HUNT0;
        pix_index    <= '0;
        frame_active <= 1'b0;
        err_timeout  <= 1'b1;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_pixel_packer.sv
module tb_uart_pixel_packer;
  import uart_pixel_packer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        rx_valid;
  logic [11:0] rx_data;
  logic [14:0] pix_index;
  logic        frame_active;
  logic        frame_done;
  logic        err_timeout;
  pk_state_e   dbg_state;

  uart_pixel_packer #(
    .W           (2),
    .H           (2),
    .TIMEOUT_CYC (24'd16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .pix_index    (pix_index),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .err_timeout  (err_timeout),
    .dbg_state    (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // entry = {frame_done expected, pixel}
  logic [12:0] exp_q[$];
  logic [12:0] exp_e;
  logic        prev_rx = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      check("rx_gap", 32'(prev_rx), 32'd0);
      check("rx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(exp_e[11:0]));
        check("frame_done", 32'(frame_done), 32'(exp_e[12]));
      end
    end else if (frame_done) begin
      check("fd_without_rx", 32'(rx_valid), 32'd1);
    end
    prev_rx = rx_valid;
  end

  // ---------------- drivers (call at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [7:0] lo, input logic [7:0] hi,
                            input logic last, input int gap);
    exp_q.push_back({last, hi[3:0], lo});
    send_byte(lo);
    idle(gap);
    send_byte(hi);
    idle(gap);
  endtask

  task automatic send_header();
    send_byte(8'hAA);
    send_byte(8'h55);
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(HUNT0));
    check({tag, "_active"}, 32'(frame_active), 32'd0);
    check({tag, "_index"}, 32'(pix_index), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check_idle_state("rst");
    rst_n = 1'b1;
    en    = 1'b1;
    idle(2);

    // 1 + 3: header, 21 03 -> 12'h321, then finish the 2x2 frame
    send_header();
    check("t1_active", 32'(frame_active), 32'd1);
    check("t1_index0", 32'(pix_index), 32'd0);
    check("t1_state", 32'(dbg_state), 32'(PIX_LO));
    send_pixel(8'h21, 8'h03, 1'b0, 0);
    check("t1_index1", 32'(pix_index), 32'd1);
    check("t1_rx_data", 32'(rx_data), 32'h321);
    for (int p = 1; p < 4; p++) begin
      send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 (p == 3), int'($urandom_range(0, 3)));
    end
    check_idle_state("t3_end");

    // 2: repeated HDR0 still locks; broken header does not
    send_byte(8'hAA);
    send_byte(8'hAA);
    send_byte(8'h55);
    check("t2_active", 32'(frame_active), 32'd1);
    send_pixel(8'hC4, 8'hF7, 1'b0, 1);
    check("t2_index", 32'(pix_index), 32'd1);
    en = 1'b0;
    idle(1);
    en = 1'b1;
    check_idle_state("t2_en_clear");
    send_byte(8'hAA);
    send_byte(8'h12);
    send_byte(8'h55);
    check_idle_state("t2_bad_hdr");

    // 4: timeout after one byte, then normal frame; err stays sticky
    send_header();
    send_byte(8'h9A);
    idle(10);
    check("t4_not_yet", 32'(frame_active), 32'd1);
    idle(10);
    check("t4_err", 32'(err_timeout), 32'd1);
    check_idle_state("t4_abort");
    send_header();
    for (int p = 0; p < 4; p++) begin
      send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), (p == 3), 2);
    end
    check("t4_err_sticky", 32'(err_timeout), 32'd1);
    check_idle_state("t4_frame2");
    // hi byte arriving on the very cycle the timeout would fire
    send_header();
    send_byte(8'h5E);
    exp_q.push_back({1'b0, 4'hB, 8'h5E});
    idle(15);
    send_byte(8'hAB);
    check("t4_prio_active", 32'(frame_active), 32'd1);
    check("t4_prio_index", 32'(pix_index), 32'd1);
    en = 1'b0;
    idle(1);
    en = 1'b1;
    check("t4_en_clears_err", 32'(err_timeout), 32'd0);

    // 5: drop en after 3 bytes
    send_header();
    send_pixel(8'h7E, 8'h0D, 1'b0, 0);
    send_byte(8'h44);
    en = 1'b0;
    send_byte(8'hAA);  // ignored while disabled
    idle(1);
    check_idle_state("t5_dis");
    check("t5_err", 32'(err_timeout), 32'd0);
    check("t5_rx_hold", 32'(rx_data), 32'hD7E);
    en = 1'b1;
    send_byte(8'h55);
    check("t5_no_hdr", 32'(frame_active), 32'd0);
    send_byte(8'h21);
    send_byte(8'h03);
    idle(2);
    check_idle_state("t5_noframe");

    // 6: async reset between lo and hi byte
    send_header();
    send_byte(8'h21);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rx_data", 32'(rx_data), 32'd0);
    check("t6_rx_valid", 32'(rx_valid), 32'd0);
    check("t6_err", 32'(err_timeout), 32'd0);
    check_idle_state("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_byte(8'h03);
    send_byte(8'h21);
    send_byte(8'h03);
    idle(2);
    check("t6_need_hdr", 32'(frame_active), 32'd0);
    // back-to-back strobes: header and full frame with no idle cycles
    send_header();
    for (int p = 0; p < 4; p++) begin
      send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), (p == 3), 0);
    end
    idle(3);
    check_idle_state("t6_b2b");
    check("q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
